loader_mesh_burst: RTL and testbench

LOADER_MESH_BURST -- requirements
Module: loader_mesh_burst

---
 rtl/loader_pkg.sv | 19 +
 rtl/tile_decoder.sv | 24 ++
 rtl/loader_mesh_burst.sv | 184 ++++++++++++++++++
 tb/tb_loader_mesh_burst.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the mesh loader family: FSM state encoding and
// the tile-index width helper used to size tile selects.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Width of a tile index; never narrower than one bit so a single-tile
    // build still has a legal select field.
    function automatic int tile_bits(input int n);
        int b;
        b = $clog2(n);
        return (b < 1) ? 1 : b;
    endfunction

endpackage

// File: rtl/tile_decoder.sv
// Tile index decoder: turns a binary tile index into a one-hot select vector
// and reports whether the index names an existing tile. Indices at or above
// NB_TILES decode to an all-zero select.
module tile_decoder
    import loader_pkg::*;
#(
    parameter int NB_TILES  = 4,
    parameter int TILE_BITS = tile_bits(NB_TILES)
) (
    input  logic [TILE_BITS-1:0] INDEX,
    output logic [NB_TILES-1:0]  SELECT,
    output logic                 IN_RANGE
);

    // One-hot decode of the index plus range flag.
    always_comb begin
        SELECT   = {NB_TILES{1'b0}};
        IN_RANGE = (int'(INDEX) < NB_TILES);
        for (int i = 0; i < NB_TILES; i++) begin
            SELECT[i] = (int'(INDEX) == i);
        end
    end

endmodule

// File: rtl/loader_mesh_burst.sv
// Burst loader for a tiled memory mesh. A command names a start address whose
// upper bits select a tile; the following CMD_LEN+1 data beats are written to
// consecutive tile-local addresses (wrapping inside the tile). Commands to a
// non-existent tile raise a one-cycle ERROR and their beats are swallowed.
module loader_mesh_burst
    import loader_pkg::*;
#(
    parameter int ADDRESS_SIZE = 10,
    parameter int DATA_SIZE    = 8,
    parameter int NB_TILES     = 4,
    parameter int LEN_SIZE     = 4,
    localparam int TILE_BITS   = tile_bits(NB_TILES),
    localparam int LOCAL_BITS  = ADDRESS_SIZE - TILE_BITS
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic [ADDRESS_SIZE-1:0] CMD_ADDR,
    input  logic [LEN_SIZE-1:0]     CMD_LEN,
    input  logic                    DIN_VALID,
    output logic                    DIN_READY,
    input  logic [DATA_SIZE-1:0]    DIN,
    input  logic [NB_TILES-1:0]     TILE_READY,
    output logic [NB_TILES-1:0]     SELECT_TILE,
    output logic [LOCAL_BITS-1:0]   ADDRESS_TILE,
    output logic [DATA_SIZE-1:0]    DATA_TILE,
    output logic                    WRITE_EN,
    output logic                    ERROR,
    output logic                    BUSY
);

    state_t                  state_r;
    state_t                  state_next_s;

    logic [TILE_BITS-1:0]    cmd_tile_s;
    logic [LOCAL_BITS-1:0]   cmd_local_s;
    logic [NB_TILES-1:0]     cmd_sel_s;
    logic                    cmd_in_range_s;

    // The latched tile is kept in one-hot form: it is exactly what the
    // write strobe and the ready mux need, so no second decode is required.
    logic [NB_TILES-1:0]     sel_r;
    logic [LOCAL_BITS-1:0]   local_addr_r;
    logic [LEN_SIZE-1:0]     count_r;

    logic                    cmd_ready_s;
    logic                    din_ready_s;
    logic                    cmd_fire_s;
    logic                    din_fire_s;
    logic                    last_beat_s;

    logic [NB_TILES-1:0]     select_tile_r;
    logic [LOCAL_BITS-1:0]   address_tile_r;
    logic [DATA_SIZE-1:0]    data_tile_r;
    logic                    write_en_r;
    logic                    error_r;
    logic                    busy_r;

    assign cmd_tile_s  = CMD_ADDR[ADDRESS_SIZE-1 -: TILE_BITS];
    assign cmd_local_s = CMD_ADDR[LOCAL_BITS-1:0];
    assign last_beat_s = (count_r == {LEN_SIZE{1'b0}});
    assign cmd_fire_s  = CMD_VALID & cmd_ready_s;
    assign din_fire_s  = DIN_VALID & din_ready_s;

    tile_decoder #(
        .NB_TILES  (NB_TILES),
        .TILE_BITS (TILE_BITS)
    ) u_tile_decoder (
        .INDEX    (cmd_tile_s),
        .SELECT   (cmd_sel_s),
        .IN_RANGE (cmd_in_range_s)
    );

    // Next-state logic and the two combinational handshake readies.
    always_comb begin
        state_next_s = state_r;
        cmd_ready_s  = 1'b0;
        din_ready_s  = 1'b0;
        case (state_r)
            IDLE: begin
                cmd_ready_s = 1'b1;
                if (CMD_VALID) begin
                    if (cmd_in_range_s) begin
                        state_next_s = BURST;
                    end else begin
                        state_next_s = DRAIN;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            BURST: begin
                // Only the latched tile's ready matters; others are masked off.
                din_ready_s = |(TILE_READY & sel_r);
                if (DIN_VALID && din_ready_s && last_beat_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = BURST;
                end
            end
            DRAIN: begin
                din_ready_s = 1'b1;
                if (DIN_VALID && last_beat_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Burst context (tile, address, beat count) and registered write port.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sel_r          <= {NB_TILES{1'b0}};
            local_addr_r   <= {LOCAL_BITS{1'b0}};
            count_r        <= {LEN_SIZE{1'b0}};
            select_tile_r  <= {NB_TILES{1'b0}};
            address_tile_r <= {LOCAL_BITS{1'b0}};
            data_tile_r    <= {DATA_SIZE{1'b0}};
            write_en_r     <= 1'b0;
            error_r        <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            if (cmd_fire_s) begin
                sel_r        <= cmd_sel_s;
                local_addr_r <= cmd_local_s;
                count_r      <= CMD_LEN;
            end else if (din_fire_s) begin
                // Counter parks at zero once the last beat has gone.
                if (!last_beat_s) begin
                    count_r <= count_r - LEN_SIZE'(1);
                end else begin
                    count_r <= {LEN_SIZE{1'b0}};
                end
                // Address wraps naturally at the local width, staying in-tile.
                if (state_r == BURST) begin
                    local_addr_r <= local_addr_r + LOCAL_BITS'(1);
                end else begin
                    local_addr_r <= local_addr_r;
                end
            end else begin
                count_r      <= count_r;
                local_addr_r <= local_addr_r;
            end

            if (din_fire_s && (state_r == BURST)) begin
                write_en_r     <= 1'b1;
                select_tile_r  <= sel_r;
                address_tile_r <= local_addr_r;
                data_tile_r    <= DIN;
            end else begin
                write_en_r     <= 1'b0;
                select_tile_r  <= {NB_TILES{1'b0}};
            end

            error_r <= cmd_fire_s & ~cmd_in_range_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    assign CMD_READY    = cmd_ready_s;
    assign DIN_READY    = din_ready_s;
    assign SELECT_TILE  = select_tile_r;
    assign ADDRESS_TILE = address_tile_r;
    assign DATA_TILE    = data_tile_r;
    assign WRITE_EN     = write_en_r;
    assign ERROR        = error_r;
    assign BUSY         = busy_r;

endmodule

// File: tb/tb_loader_mesh_burst.sv
// Directed bench for loader_mesh_burst: a 4-tile instance for the main
// scenarios and a 3-tile instance for the out-of-range command path.
module tb_loader_mesh_burst;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       cmd_valid, cmd_ready, din_valid, din_ready;
    logic [9:0] cmd_addr;
    logic [3:0] cmd_len, tile_ready, select_tile;
    logic [7:0] din, address_tile, data_tile;
    logic       write_en, error, busy;

    logic       cmd_valid3, cmd_ready3, din_valid3, din_ready3;
    logic [9:0] cmd_addr3;
    logic [3:0] cmd_len3;
    logic [2:0] tile_ready3, select_tile3;
    logic [7:0] din3, address_tile3, data_tile3;
    logic       write_en3, error3, busy3;

    loader_mesh_burst #(.ADDRESS_SIZE(10), .DATA_SIZE(8), .NB_TILES(4), .LEN_SIZE(4)) dut (
        .CLK(clk), .RESET(reset), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len), .DIN_VALID(din_valid), .DIN_READY(din_ready),
        .DIN(din), .TILE_READY(tile_ready), .SELECT_TILE(select_tile),
        .ADDRESS_TILE(address_tile), .DATA_TILE(data_tile), .WRITE_EN(write_en),
        .ERROR(error), .BUSY(busy));

    loader_mesh_burst #(.ADDRESS_SIZE(10), .DATA_SIZE(8), .NB_TILES(3), .LEN_SIZE(4)) dut3 (
        .CLK(clk), .RESET(reset), .CMD_VALID(cmd_valid3), .CMD_READY(cmd_ready3),
        .CMD_ADDR(cmd_addr3), .CMD_LEN(cmd_len3), .DIN_VALID(din_valid3), .DIN_READY(din_ready3),
        .DIN(din3), .TILE_READY(tile_ready3), .SELECT_TILE(select_tile3),
        .ADDRESS_TILE(address_tile3), .DATA_TILE(data_tile3), .WRITE_EN(write_en3),
        .ERROR(error3), .BUSY(busy3));

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t wq[$];
    int  wcyc[$];
    int  cyc = 0;
    int  w3_count = 0;
    int  n_vec = 0;
    int  n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe seen between clock edges.
    always @(negedge clk) begin
        wr_t w;
        if (write_en === 1'b1) begin
            w = {select_tile, address_tile, data_tile};
            wq.push_back(w);
            wcyc.push_back(cyc);
        end
        if (write_en3 !== 1'b0) w3_count <= w3_count + 1;
    end

    task automatic send_cmd(input logic [9:0] a, input logic [3:0] l);
        bit ok = 1'b0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk); ok = (cmd_ready === 1'b1);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        n_vec++;
        if (!ok) begin n_bad++; $display("FAIL cmd_handshake: CMD_READY never 1, required 1"); end
    endtask

    task automatic send_beat(input logic [7:0] d, input bit rbp);
        bit ok = 1'b0;
        din_valid = 1'b1; din = d;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (rbp) tile_ready = (i >= 3) ? 4'hF : 4'($urandom_range(0, 15));
            @(negedge clk); ok = (din_ready === 1'b1);
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        n_vec++;
        if (!ok) begin n_bad++; $display("FAIL din_handshake: DIN_READY never 1, required 1"); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_addr = 10'h000; cmd_len = 4'h0;
        din_valid = 1'b0; din = 8'h00; tile_ready = 4'hF;
        cmd_valid3 = 1'b0; cmd_addr3 = 10'h000; cmd_len3 = 4'h0;
        din_valid3 = 1'b0; din3 = 8'h00; tile_ready3 = 3'b111;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if ({write_en, error, busy} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b, required 000", {write_en, error, busy}); end
        n_vec++; if (select_tile !== 4'h0) begin n_bad++; $display("FAIL reset_select: got %h, required 0", select_tile); end
        n_vec++; if ({address_tile, data_tile} !== 16'h0000) begin n_bad++; $display("FAIL reset_addr_data: got %h, required 0000", {address_tile, data_tile}); end
        n_vec++; if ({cmd_ready, din_ready} !== 2'b10) begin n_bad++; $display("FAIL reset_readies: got %b, required 10", {cmd_ready, din_ready}); end
        n_vec++; if ({error3, busy3, write_en3} !== 3'b000) begin n_bad++; $display("FAIL reset_dut3: got %b, required 000", {error3, busy3, write_en3}); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        wr_t exp_w[4] = '{'{4'b0001, 8'hFE, 8'h11}, '{4'b0001, 8'hFF, 8'h22},
                          '{4'b0001, 8'h00, 8'h33}, '{4'b0001, 8'h01, 8'h44}};
        wq.delete();
        send_cmd(10'h0FE, 4'd3);
        send_beat(8'h11, 1'b0); send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0); send_beat(8'h44, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        n_vec++; if (wq.size() != 4) begin n_bad++; $display("FAIL wrap_count: got %0d writes, required 4", wq.size()); end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            n_vec++; if (wq[i] !== exp_w[i]) begin n_bad++; $display("FAIL wrap_write%0d: got %h, required %h", i, wq[i], exp_w[i]); end
        end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wrap_idle: BUSY got %b, required 0", busy); end
    endtask

    task automatic test_backpressure();
        wr_t exp_w[2] = '{'{4'b1000, 8'h05, 8'hA1}, '{4'b1000, 8'h06, 8'hA2}};
        wq.delete();
        send_cmd(10'h305, 4'd1);
        tile_ready = 4'b0111; din_valid = 1'b1; din = 8'hA1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if ({din_ready, write_en} !== 2'b00) begin n_bad++; $display("FAIL stall%0d: DIN_READY,WRITE_EN got %b, required 00", i, {din_ready, write_en}); end
            @(posedge clk); #1;
        end
        tile_ready = 4'b1000;
        send_beat(8'hA1, 1'b0); send_beat(8'hA2, 1'b0);
        tile_ready = 4'hF;
        repeat (2) begin @(posedge clk); #1; end
        n_vec++; if (wq.size() != 2) begin n_bad++; $display("FAIL bp_count: got %0d writes, required 2", wq.size()); end
        for (int i = 0; i < 2 && i < wq.size(); i++) begin
            n_vec++; if (wq[i] !== exp_w[i]) begin n_bad++; $display("FAIL bp_write%0d: got %h, required %h", i, wq[i], exp_w[i]); end
        end
    endtask

    task automatic test_error();
        cmd_valid3 = 1'b1; cmd_addr3 = 10'h3A0; cmd_len3 = 4'd2;
        @(negedge clk);
        n_vec++; if (cmd_ready3 !== 1'b1) begin n_bad++; $display("FAIL err_cmd_ready: got %b, required 1", cmd_ready3); end
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        n_vec++; if ({error3, busy3, din_ready3} !== 3'b111) begin n_bad++; $display("FAIL err_pulse: ERROR,BUSY,DIN_READY got %b, required 111", {error3, busy3, din_ready3}); end
        din_valid3 = 1'b1; din3 = 8'hEE;
        @(posedge clk); #1;
        n_vec++; if (error3 !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle: ERROR got %b, required 0", error3); end
        @(posedge clk); #1;
        n_vec++; if (busy3 !== 1'b1) begin n_bad++; $display("FAIL err_drain_2: BUSY got %b, required 1", busy3); end
        @(posedge clk); #1;
        din_valid3 = 1'b0;
        n_vec++; if ({busy3, cmd_ready3, din_ready3} !== 3'b010) begin n_bad++; $display("FAIL err_idle: BUSY,CMD_READY,DIN_READY got %b, required 010", {busy3, cmd_ready3, din_ready3}); end
        @(posedge clk); #1;
        n_vec++; if (w3_count != 0) begin n_bad++; $display("FAIL err_no_write: got %0d writes, required 0", w3_count); end
    endtask

    task automatic test_reset_mid();
        wr_t e0 = '{4'b0100, 8'h40, 8'h51};
        wq.delete();
        send_cmd(10'h240, 4'd7);
        send_beat(8'h51, 1'b0); send_beat(8'h52, 1'b0);
        n_vec++; if (write_en !== 1'b1) begin n_bad++; $display("FAIL rm_pre_write: WRITE_EN got %b, required 1", write_en); end
        reset = 1'b0;
        #1;
        n_vec++; if ({write_en, busy, error, select_tile} !== 7'h00) begin n_bad++; $display("FAIL rm_async_flags: got %h, required 00", {write_en, busy, error, select_tile}); end
        n_vec++; if ({address_tile, data_tile} !== 16'h0000) begin n_bad++; $display("FAIL rm_async_data: got %h, required 0000", {address_tile, data_tile}); end
        @(posedge clk); #1;
        reset = 1'b1;
        din_valid = 1'b1; din = 8'h5F;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++; if (din_ready !== 1'b0) begin n_bad++; $display("FAIL rm_no_beat%0d: DIN_READY got %b, required 0", i, din_ready); end
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        n_vec++; if (wq.size() != 1) begin n_bad++; $display("FAIL rm_count: got %0d writes, required 1", wq.size()); end
        if (wq.size() > 0) begin
            n_vec++; if (wq[0] !== e0) begin n_bad++; $display("FAIL rm_write0: got %h, required %h", wq[0], e0); end
        end
    endtask

    task automatic test_back_to_back();
        wq.delete(); wcyc.delete();
        send_cmd(10'h155, 4'd0);
        send_beat(8'hB1, 1'b0);
        n_vec++; if ({write_en, select_tile, address_tile, data_tile} !== {1'b1, 4'b0010, 8'h55, 8'hB1}) begin
            n_bad++; $display("FAIL b2b_first: got %h, required %h", {write_en, select_tile, address_tile, data_tile}, {1'b1, 4'b0010, 8'h55, 8'hB1}); end
        send_cmd(10'h2AA, 4'd0);
        n_vec++; if ({write_en, select_tile, address_tile, data_tile} !== {1'b0, 4'b0000, 8'h55, 8'hB1}) begin
            n_bad++; $display("FAIL b2b_hold: got %h, required %h", {write_en, select_tile, address_tile, data_tile}, {1'b0, 4'b0000, 8'h55, 8'hB1}); end
        send_beat(8'hB2, 1'b0);
        n_vec++; if ({write_en, select_tile, address_tile, data_tile} !== {1'b1, 4'b0100, 8'hAA, 8'hB2}) begin
            n_bad++; $display("FAIL b2b_second: got %h, required %h", {write_en, select_tile, address_tile, data_tile}, {1'b1, 4'b0100, 8'hAA, 8'hB2}); end
        repeat (2) begin @(posedge clk); #1; end
        n_vec++; if (wq.size() != 2) begin n_bad++; $display("FAIL b2b_count: got %0d writes, required 2", wq.size()); end
        else begin
            n_vec++; if (wcyc[1] - wcyc[0] != 2) begin n_bad++; $display("FAIL b2b_gap: got %0d cycles, required 2", wcyc[1] - wcyc[0]); end
        end
    endtask

    task automatic test_len_max();
        wr_t e;
        wq.delete();
        send_cmd(10'h1F0, 4'hF);
        for (int i = 0; i < 16; i++) begin
            send_beat(8'(i * 3 + 1), 1'b0);
            if (i == 14) begin
                n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lenmax_busy15: BUSY got %b, required 1", busy); end
            end
        end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lenmax_done: BUSY got %b, required 0", busy); end
        repeat (2) begin @(posedge clk); #1; end
        n_vec++; if (wq.size() != 16) begin n_bad++; $display("FAIL lenmax_count: got %0d writes, required 16", wq.size()); end
        for (int i = 0; i < 16 && i < wq.size(); i++) begin
            e.sel = 4'b0010; e.addr = 8'hF0 + 8'(i); e.data = 8'(i * 3 + 1);
            n_vec++; if (wq[i] !== e) begin n_bad++; $display("FAIL lenmax_write%0d: got %h, required %h", i, wq[i], e); end
        end
    endtask

    task automatic test_random();
        wr_t exp_q[$];
        wr_t e;
        logic [1:0] t;
        logic [7:0] la, d;
        logic [3:0] ln;
        wq.delete();
        for (int c = 0; c < 12; c++) begin
            t = 2'($urandom_range(0, 3)); la = 8'($urandom); ln = 4'($urandom_range(0, 3));
            send_cmd({t, la}, ln);
            for (int k = 0; k <= int'(ln); k++) begin
                d = 8'($urandom);
                send_beat(d, 1'b1);
                e.sel = 4'(1 << t); e.addr = la + 8'(k); e.data = d;
                exp_q.push_back(e);
            end
        end
        tile_ready = 4'hF;
        repeat (2) begin @(posedge clk); #1; end
        n_vec++; if (wq.size() != exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d writes, required %0d", wq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
            n_vec++; if (wq[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_write%0d: got %h, required %h", i, wq[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_backpressure();
        test_error();
        test_reset_mid();
        test_back_to_back();
        test_len_max();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
